// File: rtl/axi_sram_write_slave_if.sv
// AXI4 write-address, write-data and write-response channels between an
// interconnect master port and an SRAM-backed write slave.
interface axi_sram_write_slave_if #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [IDS_W-1:0]    AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [IDS_W-1:0]    BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );
endinterface

// File: rtl/axi_sram_write_slave.sv
// AXI4 write responder: one burst at a time, registered byte-enabled writes
// into a single-port SRAM, one B response per burst.
module axi_sram_write_slave #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  axi_sram_write_slave_if.slave axi,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [IDS_W-1:0]  id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [STRB_W-1:0] mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [LEN_W-1:0]  awlen_p1;
  logic              wrap_bad;
  logic [ADDR_W-1:0] incr, wrap_mask, next_addr;
  logic              in_range, at_last;

  // Illegal WRAP lengths are demoted to INCR at AW time so the data phase
  // only ever sees a legal power-of-two wrap window.
  assign awlen_p1 = axi.AWLEN + LEN_W'(1);
  assign wrap_bad = (axi.AWBURST == BURST_WRAP) &&
                    ((axi.AWLEN == '0) || ((axi.AWLEN & awlen_p1) != '0));

  assign incr      = ADDR_W'(1) << size_q;
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
  assign in_range  = (addr_q[ADDR_W-1:MEM_AW+2] == '0);
  assign at_last   = (cnt_q == len_q);

  always_comb begin
    next_addr = addr_q + incr;
    if (burst_q == BURST_FIXED)
      next_addr = addr_q;
    else if (burst_q == BURST_WRAP)
      next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_we_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (axi.AWVALID) begin
          id_d    = axi.AWID;
          addr_d  = axi.AWADDR;
          len_d   = axi.AWLEN;
          size_d  = axi.AWSIZE;
          burst_d = wrap_bad ? BURST_INCR : axi.AWBURST;
          cnt_d   = '0;
          err_d   = wrap_bad || (axi.AWSIZE > 3'd2);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (axi.WVALID) begin
          cnt_d       = cnt_q + LEN_W'(1);
          addr_d      = next_addr;
          mem_addr_d  = addr_q[MEM_AW+1:2];
          mem_wdata_d = axi.WDATA;
          if (in_range && (size_q <= 3'd2))
            mem_we_d = axi.WSTRB;
          if (!in_range || (axi.WLAST != at_last))
            err_d = 1'b1;
          if (axi.WLAST || at_last)
            state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (axi.BREADY)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign axi.AWREADY = (state_q == ST_IDLE);
  assign axi.WREADY  = (state_q == ST_DATA);
  assign axi.BVALID  = (state_q == ST_RESP);
  assign axi.BID     = id_q;
  assign axi.BRESP   = ((state_q == ST_RESP) && err_q) ? 2'b10 : 2'b00;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Directed bench for axi_sram_write_slave: table of bursts with hand-computed
// SRAM writes and responses, plus B back-pressure and mid-burst reset sequences.
module tb_axi_sram_write_slave;
  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;

  int n_vec;
  int n_err;

  axi_sram_write_slave_if #(.IDS_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) axi ();

  axi_sram_write_slave #(
    .IDS_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MEM_AW(14)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .axi(axi),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [7:0]        id;
    logic [4:0]        nbeats;
    logic              wlast_end;
    logic [31:0]       data0;
    logic [3:0]        strb;
    logic [1:0]        exp_resp;
    logic [15:0][13:0] exp_addr;
    logic [15:0][3:0]  exp_we;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [7:0] id, input logic [4:0] nbeats,
                              input logic wlast_end, input logic [31:0] data0,
                              input logic [3:0] strb, input logic [1:0] resp);
    vec_t v;
    v = '0;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.nbeats = nbeats; v.wlast_end = wlast_end; v.data0 = data0; v.strb = strb;
    v.exp_resp = resp;
    return v;
  endfunction

  task automatic do_aw(input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input logic [7:0] id);
    int n;
    axi.AWADDR = addr; axi.AWLEN = len; axi.AWSIZE = size;
    axi.AWBURST = burst; axi.AWID = id; axi.AWVALID = 1'b1;
    n = 0;
    while (!axi.AWREADY && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("awready", axi.AWREADY, 1);
    @(posedge ACLK); #1;
    axi.AWVALID = 1'b0;
  endtask

  task automatic run_burst(input vec_t v, input int k);
    do_aw(v.addr, v.len, v.size, v.burst, v.id);
    for (int i = 0; i < int'(v.nbeats); i++) begin
      axi.WVALID = 1'b1;
      axi.WDATA  = v.data0 + 32'(i);
      axi.WSTRB  = v.strb;
      axi.WLAST  = v.wlast_end && (i == int'(v.nbeats) - 1);
      chk($sformatf("v%0d wready b%0d", k, i), axi.WREADY, 1);
      @(posedge ACLK); #1;
      chk($sformatf("v%0d mem_we b%0d", k, i), mem_we, v.exp_we[i]);
      chk($sformatf("v%0d mem_addr b%0d", k, i), mem_addr, v.exp_addr[i]);
      chk($sformatf("v%0d mem_wdata b%0d", k, i), mem_wdata, v.data0 + 32'(i));
    end
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
    chk($sformatf("v%0d bvalid", k), axi.BVALID, 1);
    chk($sformatf("v%0d bresp", k), axi.BRESP, v.exp_resp);
    chk($sformatf("v%0d bid", k), axi.BID, v.id);
    axi.BREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.BREADY = 1'b0;
    chk($sformatf("v%0d bvalid low", k), axi.BVALID, 0);
    chk($sformatf("v%0d we idle", k), mem_we, 0);
    chk($sformatf("v%0d awready after B", k), axi.AWREADY, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ARESETn = 1'b0;
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
    axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0;
    axi.WVALID = 1'b0; axi.BREADY = 1'b0;

    vec[0]  = mk(32'h10, 4'd0, 3'd2, 2'b01, 8'hA5, 5'd1, 1'b1, 32'hDEADBEEF, 4'hF, 2'b00);
    vec[0].exp_addr[0] = 14'h4; vec[0].exp_we[0] = 4'hF;
    vec[1]  = mk(32'h100, 4'd3, 3'd2, 2'b01, 8'h11, 5'd4, 1'b1, 32'h1000_0000, 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) begin
      vec[1].exp_addr[i] = 14'h40 + 14'(i); vec[1].exp_we[i] = 4'hF;
    end
    vec[2]  = mk(32'h18, 4'd3, 3'd2, 2'b10, 8'h22, 5'd4, 1'b1, 32'h2000_0000, 4'hF, 2'b00);
    vec[2].exp_addr[0] = 14'd6; vec[2].exp_addr[1] = 14'd7;
    vec[2].exp_addr[2] = 14'd4; vec[2].exp_addr[3] = 14'd5;
    for (int i = 0; i < 4; i++) vec[2].exp_we[i] = 4'hF;
    vec[3]  = mk(32'h200, 4'd3, 3'd2, 2'b01, 8'h33, 5'd2, 1'b1, 32'h3000_0000, 4'hF, 2'b10);
    vec[3].exp_addr[0] = 14'h80; vec[3].exp_addr[1] = 14'h81;
    vec[3].exp_we[0] = 4'hF; vec[3].exp_we[1] = 4'hF;
    vec[4]  = mk(32'h0001_0000, 4'd0, 3'd2, 2'b01, 8'h44, 5'd1, 1'b1, 32'h4000_0000, 4'hF, 2'b10);
    vec[5]  = mk(32'h20, 4'd2, 3'd2, 2'b00, 8'h55, 5'd3, 1'b1, 32'h5000_0000, 4'h6, 2'b00);
    for (int i = 0; i < 3; i++) begin
      vec[5].exp_addr[i] = 14'h8; vec[5].exp_we[i] = 4'h6;
    end
    vec[6]  = mk(32'h40, 4'd1, 3'd2, 2'b01, 8'h66, 5'd2, 1'b0, 32'h6000_0000, 4'hF, 2'b10);
    vec[6].exp_addr[0] = 14'h10; vec[6].exp_addr[1] = 14'h11;
    vec[6].exp_we[0] = 4'hF; vec[6].exp_we[1] = 4'hF;
    vec[7]  = mk(32'h8, 4'd2, 3'd2, 2'b10, 8'h77, 5'd3, 1'b1, 32'h7000_0000, 4'hF, 2'b10);
    for (int i = 0; i < 3; i++) begin
      vec[7].exp_addr[i] = 14'd2 + 14'(i); vec[7].exp_we[i] = 4'hF;
    end
    vec[8]  = mk(32'h0, 4'd1, 3'd3, 2'b01, 8'h88, 5'd2, 1'b1, 32'h8000_0000, 4'hF, 2'b10);
    vec[8].exp_addr[0] = 14'd0; vec[8].exp_addr[1] = 14'd2;
    vec[9]  = mk(32'h3, 4'd1, 3'd0, 2'b01, 8'h99, 5'd2, 1'b1, 32'h9000_0000, 4'h1, 2'b00);
    vec[9].exp_addr[0] = 14'd0; vec[9].exp_addr[1] = 14'd1;
    vec[9].exp_we[0] = 4'h1; vec[9].exp_we[1] = 4'h1;
    vec[10] = mk(32'h4, 4'd1, 3'd2, 2'b10, 8'hAA, 5'd2, 1'b1, 32'hA000_0000, 4'hF, 2'b00);
    vec[10].exp_addr[0] = 14'd1; vec[10].exp_addr[1] = 14'd0;
    vec[10].exp_we[0] = 4'hF; vec[10].exp_we[1] = 4'hF;
    vec[11] = mk(32'hFFFC, 4'd1, 3'd2, 2'b01, 8'hBB, 5'd2, 1'b1, 32'hB000_0000, 4'hF, 2'b10);
    vec[11].exp_addr[0] = 14'h3FFF; vec[11].exp_addr[1] = 14'h0;
    vec[11].exp_we[0] = 4'hF;

    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    chk("rst awready", axi.AWREADY, 1);
    chk("rst wready", axi.WREADY, 0);
    chk("rst bvalid", axi.BVALID, 0);
    chk("rst bresp", axi.BRESP, 0);
    chk("rst bid", axi.BID, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);

    for (int k = 0; k < 12; k++) run_burst(vec[k], k);

    // B back-pressure with a pending AW that must not be taken
    do_aw(32'h0002_0000, 4'd0, 3'd2, 2'b01, 8'h3C);
    axi.WVALID = 1'b1; axi.WDATA = 32'h1234_5678; axi.WSTRB = 4'hF; axi.WLAST = 1'b1;
    @(posedge ACLK); #1;
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    axi.AWADDR = 32'h44; axi.AWLEN = 4'd0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01;
    axi.AWID = 8'hC3; axi.AWVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp bvalid c%0d", c), axi.BVALID, 1);
      chk($sformatf("bp bid c%0d", c), axi.BID, 8'h3C);
      chk($sformatf("bp bresp c%0d", c), axi.BRESP, 2'b10);
      chk($sformatf("bp awready c%0d", c), axi.AWREADY, 0);
      @(posedge ACLK); #1;
    end
    axi.BREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.BREADY = 1'b0;
    chk("bp awready after B", axi.AWREADY, 1);
    @(posedge ACLK); #1;
    axi.AWVALID = 1'b0;
    chk("bp next aw taken", axi.WREADY, 1);
    axi.WVALID = 1'b1; axi.WDATA = 32'hCAFE_F00D; axi.WSTRB = 4'h3; axi.WLAST = 1'b1;
    @(posedge ACLK); #1;
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    chk("bp next mem_addr", mem_addr, 14'h11);
    chk("bp next mem_we", mem_we, 4'h3);
    chk("bp next bid", axi.BID, 8'hC3);
    chk("bp next bresp", axi.BRESP, 2'b00);
    axi.BREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.BREADY = 1'b0;

    // Reset asserted mid-burst: outputs clear at once, no response follows
    do_aw(32'h300, 4'd3, 3'd2, 2'b01, 8'h5A);
    axi.WVALID = 1'b1; axi.WDATA = 32'h0BAD_0BAD; axi.WSTRB = 4'hF; axi.WLAST = 1'b0;
    @(posedge ACLK); #1;
    chk("mid mem_addr pre", mem_addr, 14'hC0);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("mid rst mem_we", mem_we, 0);
    chk("mid rst mem_addr", mem_addr, 0);
    chk("mid rst mem_wdata", mem_wdata, 0);
    chk("mid rst awready", axi.AWREADY, 1);
    chk("mid rst wready", axi.WREADY, 0);
    chk("mid rst bvalid", axi.BVALID, 0);
    chk("mid rst bid", axi.BID, 0);
    axi.WVALID = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge ACLK); #1;
      chk($sformatf("post rst bvalid c%0d", c), axi.BVALID, 0);
      chk($sformatf("post rst mem_we c%0d", c), mem_we, 0);
    end
    run_burst(vec[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_sram_write_slave.md
Name: axi_sram_write_slave

Overview:
- AXI4 write-channel responder at the slave end of the interconnect write crossbar.
- Accepts one AW burst at a time, absorbs its W beats, and issues registered byte-enabled writes to a single-port SRAM macro.
- Returns exactly one B response per burst.
- Used as the write front-end of IM, DM and similar SRAM-backed slaves.

Parameters:
- IDS_W, 8, slave-side ID width (master index concatenated with master ID)
- ADDR_W, 32, AXI address width; the address is already slave-relative
- DATA_W, 32, data width; STRB_W = DATA_W/8
- LEN_W, 4, AWLEN width; bursts are 1..16 beats
- MEM_AW, 14, SRAM word-address width (2^MEM_AW words)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWID  in  IDS_W  burst ID
- AWADDR  in  ADDR_W  start byte address
- AWLEN  in  LEN_W  beats minus 1
- AWSIZE  in  3  log2 bytes per beat; only 0..2 are legal
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- AWVALID/AWREADY  in/out  1  AW handshake
- WDATA  in  DATA_W  write data
- WSTRB  in  STRB_W  byte strobes
- WLAST  in  1  last beat
- WVALID/WREADY  in/out  1  W handshake
- BID  out  IDS_W  response ID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID/BREADY  out/in  1  B handshake
- mem_we  out  STRB_W  SRAM byte write enables, active-high
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  DATA_W  SRAM write data

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - AWREADY=1, WREADY=0, BVALID=0, BRESP=00, BID=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Beat counter, address register and error flag cleared.
- Reset mid-burst: the burst is abandoned immediately, with no further SRAM writes and no B response.
- FSM IDLE -> DATA -> RESP -> IDLE.
  - IDLE: AWREADY=1. On AWVALID, latch ID, ADDR, LEN, SIZE and BURST; clear the counter and error flag; go to DATA. W beats are not accepted in IDLE.
  - DATA: WREADY=1 and AWREADY=0. Each WVALID&&WREADY beat increments the counter and advances the address. After the final accepted beat, go to RESP.
  - RESP: BVALID=1, BID=latched ID, BRESP=error flag ? 10 : 00. BVALID is held until BREADY. On the handshake, go to IDLE. A new AW is first accepted the cycle after the B handshake.
- Burst end:
  - The counter equals LEN: the burst ends whether or not WLAST is set. WLAST=0 at that point sets the error flag.
  - WLAST=1 with the counter less than LEN: the burst ends early and the error flag is set.
- Address advance (byte address, width ADDR_W):
  - FIXED: unchanged.
  - INCR: addr + (1<<SIZE).
  - WRAP: the low bits wrap inside a (LEN+1)<<SIZE-byte aligned window; upper bits are held.
  - WRAP with LEN not in {1,3,7,15}: treated as INCR and sets the error flag.
  - SIZE>2: sets the error flag; no beats are written, but all beats are still consumed.
- SRAM write:
  - Registered, 1-cycle latency: mem_we, mem_addr and mem_wdata update in the cycle after the beat handshake. mem_we returns to 0 in the next cycle if no beat was accepted.
  - Word address = addr[MEM_AW+1:2].
  - mem_we = WSTRB gated by the beat being in range.
  - Out of range: any addr bit at or above MEM_AW+2 is set. The beat is dropped (mem_we=0) and the error flag is set.
  - Strobes are passed through unmodified; no narrow-transfer lane masking is performed.
- Back-to-back throughput: one beat per cycle while WVALID is held.
- Minimum burst overhead: 1 cycle for AW plus 1 cycle for B.

Test Plan:
- Single write: AWADDR=0x10, LEN=0, SIZE=2, INCR, WDATA=0xDEADBEEF, WSTRB=F, WLAST=1 -> next cycle mem_we=F, mem_addr=4, mem_wdata=0xDEADBEEF; then BVALID with BRESP=00 and BID echoing AWID.
- INCR burst: ADDR=0x100, LEN=3, four beats back-to-back -> mem_addr 0x40,0x41,0x42,0x43 on consecutive cycles; one B response, OKAY.
- WRAP burst: ADDR=0x18, LEN=3, SIZE=2 -> word addresses 6,7,4,5; OKAY.
- WLAST early: LEN=3, WLAST on beat 2 -> two writes, then BRESP=10; the next AW is accepted normally.
- Out of range: MEM_AW=14, ADDR=0x0001_0000 -> mem_we stays 0 and BRESP=10.
- BREADY held low 5 cycles -> BVALID/BID/BRESP stable and AWREADY=0 throughout. Asserting ARESETn=0 during DATA -> all outputs immediately at reset values and no B response.
